// File: rtl/io_rd_arbiter.sv
// Round-robin refill of per-PE one-word read buffers from a shared upstream read port.
// Each pe_io sees a private read queue; the upstream word arrives one cycle after the pop strobe.
module io_rd_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            flush,
  input  logic [NUM_PORTS-1:0]            src_avail,
  output logic                            src_rd_en,
  output logic [SEL_WIDTH-1:0]            src_rd_sel,
  input  logic [DATA_WIDTH-1:0]           src_data,
  input  logic [NUM_PORTS-1:0]            req_rd_data,
  output logic [NUM_PORTS-1:0]            available_read,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  output logic                            busy,
  output logic [31:0]                     grant_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [NUM_PORTS-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_PORTS];
  logic                  iss_vld_q, iss_vld_d;
  logic [SEL_WIDTH-1:0]  iss_sel_q, iss_sel_d;
  logic                  ret_vld_q, ret_vld_d;
  logic [SEL_WIDTH-1:0]  ret_sel_q, ret_sel_d;
  logic [SEL_WIDTH-1:0]  rr_q, rr_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [NUM_PORTS-1:0]  elig;
  logic                  grant_vld;
  logic [SEL_WIDTH-1:0]  grant_sel;
  logic [SEL_WIDTH:0]    cand;
  logic                  wr_en;

  // A port with a pop on the wire (iss) or a word landing (ret) must not be fetched again.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = (state_q == ST_RUN) && src_avail[i] && !valid_q[i]
                && !(iss_vld_q && (iss_sel_q == SEL_WIDTH'(i)))
                && !(ret_vld_q && (ret_sel_q == SEL_WIDTH'(i)));
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_q} + (SEL_WIDTH+1)'(k);
      if (cand >= (SEL_WIDTH+1)'(NUM_PORTS)) begin
        cand = cand - (SEL_WIDTH+1)'(NUM_PORTS);
      end
      if (!grant_vld && elig[cand[SEL_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_sel = cand[SEL_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    iss_vld_d = 1'b0;
    iss_sel_d = iss_sel_q;
    ret_vld_d = iss_vld_q;
    ret_sel_d = iss_sel_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // flush wins over everything happening in the same cycle, including a landing word
        if (flush) begin
          state_d   = ST_IDLE;
          valid_d   = '0;
          ret_vld_d = 1'b0;
          rr_d      = '0;
        end else begin
          valid_d = valid_q & ~req_rd_data;
          if (ret_vld_q) begin
            valid_d[ret_sel_q] = 1'b1;
            wr_en              = 1'b1;
          end
          if (grant_vld) begin
            iss_vld_d = 1'b1;
            iss_sel_d = grant_sel;
            rr_d      = (grant_sel == SEL_WIDTH'(NUM_PORTS-1)) ? '0 : grant_sel + SEL_WIDTH'(1);
            cnt_d     = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      iss_vld_q <= 1'b0;
      iss_sel_q <= '0;
      ret_vld_q <= 1'b0;
      ret_sel_q <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      iss_vld_q <= iss_vld_d;
      iss_sel_q <= iss_sel_d;
      ret_vld_q <= ret_vld_d;
      ret_sel_q <= ret_sel_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Buffer contents persist after consume; only valid_q says whether they are fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_en && (ret_sel_q == SEL_WIDTH'(i))) data_q[i] <= src_data;
      end
    end
  end

  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      data_in[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
    end
  end

  assign src_rd_en      = iss_vld_q;
  assign src_rd_sel     = iss_sel_q;
  assign available_read = valid_q;
  assign busy           = (state_q == ST_RUN);
  assign grant_cnt      = cnt_q;

endmodule

// File: tb/tb_io_rd_arbiter.sv
// Bench for io_rd_arbiter: random and directed scenarios against a cycle-time reference model
// that tracks each port's fetch by the cycle its word becomes visible.
module tb_io_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int SW = 2;

  logic          clk, rst, start, flush;
  logic [N-1:0]  src_avail, req_rd_data, available_read;
  logic          src_rd_en;
  logic [SW-1:0] src_rd_sel;
  logic [DW-1:0] src_data;
  logic [N*DW-1:0] data_in;
  logic          busy;
  logic [31:0]   grant_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a granted port's word is visible at grant cycle + 3.
  bit            m_run;
  logic [N-1:0]  m_valid;
  logic [DW-1:0] m_data [N];
  int            m_land [N];
  int            m_rr;
  logic [31:0]   m_cnt;
  bit            m_en;
  logic [SW-1:0] exp_q[$];

  io_rd_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .src_avail(src_avail), .src_rd_en(src_rd_en), .src_rd_sel(src_rd_sel),
    .src_data(src_data), .req_rd_data(req_rd_data),
    .available_read(available_read), .data_in(data_in),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = '0;
    m_rr    = 0;
    m_cnt   = '0;
    m_en    = 1'b0;
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      m_data[p] = '0;
      m_land[p] = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and move to #1 after the next edge.
  task automatic tick(input logic [N-1:0] avail, input logic [N-1:0] req,
                      input bit st, input bit fl, input logic [DW-1:0] word);
    int g;
    bit nxt_en;
    src_avail = avail; req_rd_data = req; start = st; flush = fl; src_data = word;
    g = -1;
    nxt_en = 1'b0;
    if (m_run) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (g < 0 && avail[p] && !m_valid[p] && m_land[p] <= cyc) g = p;
      end
    end
    if (m_run && fl) begin
      m_run = 1'b0;
      m_valid = '0;
      m_rr = 0;
      for (int p = 0; p < N; p++) m_land[p] = 0;
    end else if (m_run) begin
      m_valid = m_valid & ~req;
      for (int p = 0; p < N; p++) begin
        if (m_land[p] == cyc + 1) begin
          m_valid[p] = 1'b1;
          m_data[p]  = word;
        end
      end
      if (g >= 0) begin
        m_land[g] = cyc + 3;
        m_rr = (g + 1) % N;
        m_cnt = m_cnt + 32'd1;
        nxt_en = 1'b1;
        exp_q.push_back(SW'(g));
      end
    end else if (st && !fl) begin
      m_run = 1'b1;
      m_cnt = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_en = nxt_en;
  endtask

  task automatic restart();
    tick('0, '0, 1'b0, 1'b1, rand_word());
    exp_q.delete();
    tick('0, '0, 1'b1, 1'b0, rand_word());
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    src_avail = '0; req_rd_data = '0; src_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (available_read !== '0 || busy !== 1'b0 || src_rd_en !== 1'b0 || grant_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_held: avail=%b busy=%b en=%b cnt=%0d, required 0/0/0/0",
               available_read, busy, src_rd_en, grant_cnt);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(4'hF, 4'h0, 1'b0, 1'b0, rand_word());
      n_cmp++;
      if (src_rd_en !== 1'b0 || available_read !== 4'h0 || busy !== 1'b0 || grant_cnt !== 32'd0) begin
        n_bad++;
        $display("FAIL idle_no_start cyc=%0d: en=%b avail=%b busy=%b cnt=%0d, required all 0",
                 cyc, src_rd_en, available_read, busy, grant_cnt);
      end
    end
    for (int p = 0; p < N; p++) begin
      n_cmp++;
      if (data_in[p*DW +: DW] !== '0) begin
        n_bad++;
        $display("FAIL reset_data port=%0d got=%h required 0", p, data_in[p*DW +: DW]);
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] a5;
    logic [N-1:0]  req;
    logic [SW-1:0] exp_sel;
    int pops;
    bit pulsed;
    a5 = DW'(8'hA5);
    pops = 0;
    pulsed = 1'b0;
    tick('0, '0, 1'b1, 1'b0, a5);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (src_rd_en !== m_en) begin
        n_bad++;
        $display("FAIL single_en cyc=%0d got=%b required=%b", cyc, src_rd_en, m_en);
      end
      if (m_en) begin
        exp_sel = exp_q.pop_front();
        n_cmp++;
        if (src_rd_sel !== exp_sel || src_rd_sel !== 2'd2) begin
          n_bad++;
          $display("FAIL single_sel cyc=%0d got=%0d required=%0d", cyc, src_rd_sel, exp_sel);
        end
      end
      if (src_rd_en === 1'b1) pops++;
      n_cmp++;
      if (available_read !== m_valid) begin
        n_bad++;
        $display("FAIL single_avail cyc=%0d got=%b required=%b", cyc, available_read, m_valid);
      end
      req = '0;
      if (!pulsed && m_valid[2]) begin
        req = 4'b0100;
        pulsed = 1'b1;
      end
      tick(4'b0100, req, 1'b0, 1'b0, a5);
    end
    n_cmp++;
    if (pops !== 2) begin
      n_bad++;
      $display("FAIL single_pops got=%0d required=2", pops);
    end
    n_cmp++;
    if (grant_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL single_grant_cnt got=%0d required=2", grant_cnt);
    end
    n_cmp++;
    if (available_read !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_final_avail got=%b required=0100", available_read);
    end
    n_cmp++;
    if (data_in[2*DW +: DW] !== a5) begin
      n_bad++;
      $display("FAIL single_data got=%h required=%h", data_in[2*DW +: DW], a5);
    end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int pops;
    logic [SW-1:0] exp_sel;
    for (int p = 0; p < N; p++) cnt[p] = 0;
    pops = 0;
    restart();
    for (int i = 0; i < 300 && pops < 40; i++) begin
      n_cmp++;
      if (src_rd_en !== m_en) begin
        n_bad++;
        $display("FAIL rr_en cyc=%0d got=%b required=%b", cyc, src_rd_en, m_en);
      end
      if (m_en) begin
        exp_sel = exp_q.pop_front();
        n_cmp++;
        if (src_rd_sel !== exp_sel) begin
          n_bad++;
          $display("FAIL rr_sel_model cyc=%0d got=%0d required=%0d", cyc, src_rd_sel, exp_sel);
        end
      end
      if (src_rd_en === 1'b1) begin
        n_cmp++;
        if (src_rd_sel !== SW'(pops % N)) begin
          n_bad++;
          $display("FAIL rr_order pop=%0d got=%0d required=%0d", pops, src_rd_sel, pops % N);
        end
        cnt[src_rd_sel]++;
        pops++;
      end
      n_cmp++;
      if (available_read !== m_valid || grant_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL rr_state cyc=%0d avail=%b/%b cnt=%0d/%0d (got/required)",
                 cyc, available_read, m_valid, grant_cnt, m_cnt);
      end
      for (int p = 0; p < N; p++) begin
        n_cmp++;
        if (data_in[p*DW +: DW] !== m_data[p]) begin
          n_bad++;
          $display("FAIL rr_data cyc=%0d port=%0d got=%h required=%h", cyc, p, data_in[p*DW +: DW], m_data[p]);
        end
      end
      tick(4'hF, m_valid, 1'b0, 1'b0, rand_word());
    end
    n_cmp++;
    if (pops !== 40) begin
      n_bad++;
      $display("FAIL rr_timeout pops=%0d required=40", pops);
    end
    for (int p = 0; p < N; p++) begin
      n_cmp++;
      if (cnt[p] !== 10) begin
        n_bad++;
        $display("FAIL rr_fair port=%0d got=%0d required=10", p, cnt[p]);
      end
    end
  endtask

  task automatic test_no_double_fetch();
    int cnt [N];
    logic [SW-1:0] exp_sel;
    for (int p = 0; p < N; p++) cnt[p] = 0;
    restart();
    for (int i = 0; i < 80; i++) begin
      n_cmp++;
      if (src_rd_en !== m_en) begin
        n_bad++;
        $display("FAIL nodbl_en cyc=%0d got=%b required=%b", cyc, src_rd_en, m_en);
      end
      if (m_en) begin
        exp_sel = exp_q.pop_front();
        n_cmp++;
        if (src_rd_sel !== exp_sel) begin
          n_bad++;
          $display("FAIL nodbl_sel cyc=%0d got=%0d required=%0d", cyc, src_rd_sel, exp_sel);
        end
      end
      if (src_rd_en === 1'b1) cnt[src_rd_sel]++;
      n_cmp++;
      if (available_read !== m_valid) begin
        n_bad++;
        $display("FAIL nodbl_avail cyc=%0d got=%b required=%b", cyc, available_read, m_valid);
      end
      tick(4'hF, m_valid & 4'b1101, 1'b0, 1'b0, rand_word());
    end
    n_cmp++;
    if (cnt[1] !== 1) begin
      n_bad++;
      $display("FAIL nodbl_port1 pops=%0d required=1", cnt[1]);
    end
    for (int p = 0; p < N; p++) begin
      if (p != 1) begin
        n_cmp++;
        if (cnt[p] < 10) begin
          n_bad++;
          $display("FAIL nodbl_cycling port=%0d pops=%0d required>=10", p, cnt[p]);
        end
      end
    end
  endtask

  task automatic test_flush_mid();
    logic [SW-1:0] exp_sel;
    bit found;
    restart();
    tick(4'b1000, '0, 1'b0, 1'b0, rand_word());
    n_cmp++;
    if (src_rd_en !== 1'b1 || src_rd_sel !== 2'd3) begin
      n_bad++;
      $display("FAIL flush_pop3 got en=%b sel=%0d required en=1 sel=3", src_rd_en, src_rd_sel);
    end
    if (m_en) exp_sel = exp_q.pop_front();
    tick(4'b0010, '0, 1'b0, 1'b0, rand_word());
    n_cmp++;
    if (src_rd_en !== 1'b1 || src_rd_sel !== 2'd1) begin
      n_bad++;
      $display("FAIL flush_pop1 got en=%b sel=%0d required en=1 sel=1", src_rd_en, src_rd_sel);
    end
    if (m_en) exp_sel = exp_q.pop_front();
    // port 3's word is on src_data in this cycle
    tick('0, '0, 1'b0, 1'b1, rand_word());
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (available_read !== 4'h0 || busy !== 1'b0 || src_rd_en !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_after cyc=%0d avail=%b busy=%b en=%b required 0/0/0",
                 cyc, available_read, busy, src_rd_en);
      end
      tick(4'hF, '0, 1'b0, 1'b0, rand_word());
    end
    exp_q.delete();
    tick(4'hF, '0, 1'b1, 1'b0, rand_word());
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (src_rd_en === 1'b1) begin
        found = 1'b1;
        n_cmp++;
        if (src_rd_sel !== 2'd0) begin
          n_bad++;
          $display("FAIL flush_restart_sel got=%0d required=0", src_rd_sel);
        end
      end
      tick(4'hF, '0, 1'b0, 1'b0, rand_word());
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL flush_restart_timeout got=no pop required=pop within 8 cycles");
    end
  endtask

  task automatic test_async_reset();
    int i;
    restart();
    i = 0;
    while (m_valid !== 4'hF && i < 20) begin
      tick(4'hF, '0, 1'b0, 1'b0, rand_word());
      i++;
    end
    n_cmp++;
    if (available_read !== 4'hF) begin
      n_bad++;
      $display("FAIL areset_full got=%b required=1111", available_read);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (available_read !== 4'h0 || busy !== 1'b0 || src_rd_en !== 1'b0 || grant_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL areset_immediate avail=%b busy=%b en=%b cnt=%0d required 0/0/0/0",
               available_read, busy, src_rd_en, grant_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(4'hF, '0, 1'b0, 1'b0, rand_word());
      n_cmp++;
      if (available_read !== 4'h0 || src_rd_en !== 1'b0 || data_in !== '0) begin
        n_bad++;
        $display("FAIL areset_after cyc=%0d avail=%b en=%b data_zero=%b required 0/0/1",
                 cyc, available_read, src_rd_en, data_in == '0);
      end
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] exp_sel;
    bit fl;
    restart();
    for (int i = 0; i < 400; i++) begin
      n_cmp++;
      if (src_rd_en !== m_en) begin
        n_bad++;
        $display("FAIL rand_en cyc=%0d got=%b required=%b", cyc, src_rd_en, m_en);
      end
      if (m_en) begin
        exp_sel = exp_q.pop_front();
        n_cmp++;
        if (src_rd_sel !== exp_sel) begin
          n_bad++;
          $display("FAIL rand_sel cyc=%0d got=%0d required=%0d", cyc, src_rd_sel, exp_sel);
        end
      end
      n_cmp++;
      if (available_read !== m_valid || busy !== m_run || grant_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL rand_state cyc=%0d avail=%b/%b busy=%b/%b cnt=%0d/%0d (got/required)",
                 cyc, available_read, m_valid, busy, m_run, grant_cnt, m_cnt);
      end
      for (int p = 0; p < N; p++) begin
        n_cmp++;
        if (data_in[p*DW +: DW] !== m_data[p]) begin
          n_bad++;
          $display("FAIL rand_data cyc=%0d port=%0d got=%h required=%h", cyc, p, data_in[p*DW +: DW], m_data[p]);
        end
      end
      fl = ($urandom_range(0, 39) == 0);
      tick(N'($urandom), N'($urandom), !m_run, fl, rand_word());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_double_fetch();
    test_flush_mid();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
